// File: rtl/uart_rx.sv
// uart_rx
//   Receive end of the 8N1-style UART link: LSB first, one start bit,
//   DATA_BITS data bits, one stop bit and no parity. The raw line is
//   synchronised, each bit is sampled at its centre, and every good word is
//   presented with a one-cycle valid strobe.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-high
//   rx_serial    raw serial line, idle high, asynchronous to clk
//   rx_data      last correctly framed word (bit 0 = first data bit on the line)
//   rx_valid     1-cycle pulse: rx_data has just been updated
//   frame_error  1-cycle pulse: stop bit sampled low, word discarded
//   busy         high in every state except IDLE
module uart_rx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int DATA_BITS     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int BAUD_DIV = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF     = BAUD_DIV / 2;
  localparam int CNT_W    = $clog2(BAUD_DIV);
  localparam int IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t               state;
  logic                 sync_meta;
  logic                 rx_sync;
  logic [CNT_W-1:0]     count;
  logic [IDX_W-1:0]     index;
  logic [DATA_BITS-1:0] shift;

  // Two-flop synchroniser; both stages reset to the idle (high) level so a
  // reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b1;
      rx_sync   <= 1'b1;
    end else begin
      sync_meta <= rx_serial;
      rx_sync   <= sync_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      index       <= '0;
      shift       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_sync) begin
            state <= START;
            count <= '0;
            busy  <= 1'b1;
          end
        end

        // Re-check the line half a bit in; a short low glitch is dropped here.
        START: begin
          if (count == CNT_W'(HALF - 1)) begin
            count <= '0;
            if (!rx_sync) begin
              state <= DATA;
              index <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            count <= count + CNT_W'(1);
          end
        end

        // The counter wraps each bit period, so every sample lands on a bit centre.
        DATA: begin
          if (count == CNT_W'(BAUD_DIV - 1)) begin
            count        <= '0;
            shift[index] <= rx_sync;
            if (index == IDX_W'(DATA_BITS - 1)) begin
              state <= STOP;
            end else begin
              index <= index + IDX_W'(1);
            end
          end else begin
            count <= count + CNT_W'(1);
          end
        end

        // Leaving at the stop-bit centre gives IDLE half a bit of margin to
        // catch a back-to-back start edge.
        STOP: begin
          if (count == CNT_W'(BAUD_DIV - 1)) begin
            count <= '0;
            if (rx_sync) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              frame_error <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            count <= count + CNT_W'(1);
          end
        end

        // A line held low (break) must return high before a new frame can start.
        BREAK: begin
          if (rx_sync) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          count <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int BIT_CLKS = 16;               // 1_600_000 / 100_000
  localparam int LATENCY  = 3 + 8 + 9 * 16;   // drive edge -> rx_valid cycle

  logic       clk;
  logic       reset;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       busy;

  uart_rx #(
    .CLK_FREQUENCY(1_600_000),
    .BAUD_RATE    (100_000),
    .DATA_BITS    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_serial  (rx_serial),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: each transmitted frame yields one expected event at a
  // fixed cycle computed from the line timing.
  typedef struct {
    bit         err;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_good = 8'h00;

  // Transmitter model: drives one frame on rx_serial, called at a negedge.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok);
    exp_t e;
    logic [9:0] bits;
    e.err  = !stop_ok;
    e.at   = cyc + LATENCY;
    if (stop_ok) last_good = d;
    e.data = last_good;
    exp_q.push_back(e);
    bits = {stop_ok, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_serial = bits[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!reset && (rx_valid || frame_error)) begin
      check("valid_and_error_exclusive", {31'd0, rx_valid & frame_error}, 32'd0);
      if (exp_q.size() == 0) begin
        check("spurious_pulse", {30'd0, rx_valid, frame_error}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind", {31'd0, frame_error}, {31'd0, e.err});
        check("pulse_cycle", cyc, e.at);
        check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        if (rx_valid) check("busy_low_on_valid", {31'd0, busy}, 32'd0);
        $display("rx %s data=%02h cycle=%0d", frame_error ? "frame_err" : "word", rx_data, cyc);
      end
    end
  end

  task automatic wait_drained(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    bit         err;
    reset     = 1'b1;
    rx_serial = 1'b1;

    // 1: reset state
    repeat (5) begin
      @(negedge clk);
      check("reset_outputs", {21'd0, rx_data, rx_valid, frame_error, busy}, 32'd0);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // 2: single frame
    send_frame(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    wait_drained("a5_received");
    check("busy_idle_after_a5", {31'd0, busy}, 32'd0);

    // 3: 4-clk glitch is rejected
    rx_serial = 1'b0;
    repeat (4) @(negedge clk);
    rx_serial = 1'b1;
    repeat (4) @(negedge clk);
    check("glitch_busy_in_start", {31'd0, busy}, 32'd1);
    repeat (30) @(negedge clk);
    check("glitch_busy_cleared", {31'd0, busy}, 32'd0);
    check("glitch_data_kept", {24'd0, rx_data}, 32'h000000A5);

    // 4: bad stop bit followed by a held-low line
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    check("break_busy_high", {31'd0, busy}, 32'd1);
    rx_serial = 1'b1;
    repeat (6) @(negedge clk);
    check("break_busy_cleared", {31'd0, busy}, 32'd0);
    wait_drained("frame_error_seen");
    check("data_after_error", {24'd0, rx_data}, 32'h000000A5);
    repeat (10) @(negedge clk);

    // 5: back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    repeat (20) @(negedge clk);
    wait_drained("back_to_back");

    // 6: reset during data bit 4, then abort the partial frame
    rx_serial = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_serial = i[0];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx_serial = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midframe_reset_outputs", {21'd0, rx_data, rx_valid, frame_error, busy}, 32'd0);
    reset     = 1'b0;
    last_good = 8'h00;
    repeat (30) @(negedge clk);
    check("after_reset_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h81, 1'b1);
    repeat (20) @(negedge clk);
    wait_drained("post_reset_81");

    // Loopback sweep of every byte value, back to back
    for (int v = 0; v < 256; v++) send_frame(8'(v), 1'b1);
    repeat (20) @(negedge clk);
    wait_drained("sweep_00_ff");

    // Randomised frames, gaps and occasional framing errors
    for (int k = 0; k < 40; k++) begin
      d   = 8'($urandom);
      err = ($urandom_range(0, 7) == 0);
      send_frame(d, !err);
      if (err) begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
        rx_serial = 1'b1;
        repeat ($urandom_range(4, 20)) @(negedge clk);
      end else if ($urandom_range(0, 2) != 0) begin
        repeat ($urandom_range(1, 40)) @(negedge clk);
      end
    end
    repeat (20) @(negedge clk);
    wait_drained("random_frames");
    check("final_rx_data", {24'd0, rx_data}, {24'd0, last_good});
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
